// File: rtl/time_subtractor.sv
// Sequential BCD time subtractor: remaining time A - B, one digit per clock, LSB first.
// Optional `WRAP_24H_EN: on A < B the result wraps to A - B + 24:00:00 instead of saturating to 00:00:00.
module time_subtractor (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] aHour10,
  input  logic [3:0] aHour1,
  input  logic [3:0] aMinute10,
  input  logic [3:0] aMinute1,
  input  logic [3:0] aSecond10,
  input  logic [3:0] aSecond1,
  input  logic [3:0] bHour10,
  input  logic [3:0] bHour1,
  input  logic [3:0] bMinute10,
  input  logic [3:0] bMinute1,
  input  logic [3:0] bSecond10,
  input  logic [3:0] bSecond1,
  output logic [3:0] Hour10,
  output logic [3:0] Hour1,
  output logic [3:0] Minute10,
  output logic [3:0] Minute1,
  output logic [3:0] Second10,
  output logic [3:0] Second1,
  output logic       complete,
  output logic       busy,
  output logic       negative,
  output logic       error,
  output logic [1:0] dbg_state
);

  // Handshake: start is accepted only on an edge where the block is IDLE; complete
  // pulses for exactly one cycle when the outputs are updated, and busy covers the gap.
  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, ADJ = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q;
  logic       borrow_q;
  logic       err_q;
  logic [3:0] a_q [6];
  logic [3:0] b_q [6];
  logic [3:0] w_q [6];

  logic [3:0] a_dig, b_dig, mod_dig, d_digit;
  logic [4:0] diff;
  logic       ops_valid;

  function automatic logic time_ok(input logic [3:0] h10, input logic [3:0] h1,
                                   input logic [3:0] m10, input logic [3:0] m1,
                                   input logic [3:0] s10, input logic [3:0] s1);
    logic ok;
    ok = (h1 <= 4'd9) && (m1 <= 4'd9) && (s1 <= 4'd9);
    ok = ok && (m10 <= 4'd5) && (s10 <= 4'd5) && (h10 <= 4'd2);
    ok = ok && !((h10 == 4'd2) && (h1 > 4'd3));
    return ok;
  endfunction

  assign ops_valid = time_ok(aHour10, aHour1, aMinute10, aMinute1, aSecond10, aSecond1) &&
                     time_ok(bHour10, bHour1, bMinute10, bMinute1, bSecond10, bSecond1);
  assign dbg_state = state_q;

  // Index order: 0=Second1, 1=Second10, 2=Minute1, 3=Minute10, 4=Hour1, 5=Hour10.
  always_comb begin
    a_dig   = a_q[0];
    b_dig   = b_q[0];
    mod_dig = 4'd10;
    case (idx_q)
      3'd1: begin a_dig = a_q[1]; b_dig = b_q[1]; mod_dig = 4'd6; end
      3'd2: begin a_dig = a_q[2]; b_dig = b_q[2]; end
      3'd3: begin a_dig = a_q[3]; b_dig = b_q[3]; mod_dig = 4'd6; end
      3'd4: begin a_dig = a_q[4]; b_dig = b_q[4]; end
      3'd5: begin a_dig = a_q[5]; b_dig = b_q[5]; end
      default: ;
    endcase
    diff    = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, borrow_q};
    // diff[4] is the sign; the low nibble wraps correctly when the modulus is added back.
    d_digit = diff[4] ? (diff[3:0] + mod_dig) : diff[3:0];
  end

`ifdef WRAP_24H_EN
  logic [4:0] h1_sum, h10_sum;
  logic       h1_carry;
  logic [3:0] h1_wrap, h10_wrap;

  always_comb begin
    h1_sum   = {1'b0, w_q[4]} + 5'd4;
    h1_carry = (h1_sum > 5'd9);
    h1_wrap  = h1_carry ? (h1_sum[3:0] - 4'd10) : h1_sum[3:0];
    h10_sum  = {1'b0, w_q[5]} + 5'd2 + {4'd0, h1_carry};
    h10_wrap = (h10_sum > 5'd9) ? (h10_sum[3:0] - 4'd10) : h10_sum[3:0];
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SUB;
      SUB:     if (idx_q == 3'd5) state_d = ADJ;
      ADJ:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q    <= 3'd0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        a_q[i] <= 4'd0;
        b_q[i] <= 4'd0;
        w_q[i] <= 4'd0;
      end
      {Hour10, Hour1, Minute10, Minute1, Second10, Second1} <= 24'd0;
      complete <= 1'b0;
      busy     <= 1'b0;
      negative <= 1'b0;
      error    <= 1'b0;
    end else begin
      complete <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q[0] <= aSecond1;  a_q[1] <= aSecond10; a_q[2] <= aMinute1;
            a_q[3] <= aMinute10; a_q[4] <= aHour1;    a_q[5] <= aHour10;
            b_q[0] <= bSecond1;  b_q[1] <= bSecond10; b_q[2] <= bMinute1;
            b_q[3] <= bMinute10; b_q[4] <= bHour1;    b_q[5] <= bHour10;
            err_q    <= !ops_valid;
            borrow_q <= 1'b0;
            idx_q    <= 3'd0;
            busy     <= 1'b1;
          end
        end
        SUB: begin
          w_q[idx_q] <= d_digit;
          borrow_q   <= diff[4];
          idx_q      <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        ADJ: begin
          complete <= 1'b1;
          busy     <= 1'b0;
          if (err_q) begin
            {Hour10, Hour1, Minute10, Minute1, Second10, Second1} <= 24'd0;
            negative <= 1'b0;
            error    <= 1'b1;
          end else begin
            negative <= borrow_q;
            error    <= 1'b0;
            if (!borrow_q) begin
              {Hour10, Hour1, Minute10, Minute1, Second10, Second1} <=
                {w_q[5], w_q[4], w_q[3], w_q[2], w_q[1], w_q[0]};
            end else begin
`ifdef WRAP_24H_EN
              {Hour10, Hour1, Minute10, Minute1, Second10, Second1} <=
                {h10_wrap, h1_wrap, w_q[3], w_q[2], w_q[1], w_q[0]};
`else
              {Hour10, Hour1, Minute10, Minute1, Second10, Second1} <= 24'd0;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_subtractor.sv
// Bench for time_subtractor: directed scenarios plus random operations against a seconds-based model.
// Expectations follow `WRAP_24H_EN when the bench is compiled with it.
module tb_time_subtractor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] aHour10, aHour1, aMinute10, aMinute1, aSecond10, aSecond1;
  logic [3:0] bHour10, bHour1, bMinute10, bMinute1, bSecond10, bSecond1;
  logic [3:0] Hour10, Hour1, Minute10, Minute1, Second10, Second1;
  logic       complete, busy, negative, error;
  logic [1:0] dbg_state;

  logic [25:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  time_subtractor dut (
    .clock(clock), .reset(reset), .start(start),
    .aHour10(aHour10), .aHour1(aHour1), .aMinute10(aMinute10),
    .aMinute1(aMinute1), .aSecond10(aSecond10), .aSecond1(aSecond1),
    .bHour10(bHour10), .bHour1(bHour1), .bMinute10(bMinute10),
    .bMinute1(bMinute1), .bSecond10(bSecond10), .bSecond1(bSecond1),
    .Hour10(Hour10), .Hour1(Hour1), .Minute10(Minute10),
    .Minute1(Minute1), .Second10(Second10), .Second1(Second1),
    .complete(complete), .busy(busy), .negative(negative), .error(error),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Times are packed as {H10,H1,M10,M1,S10,S1}.
  function automatic logic valid_t(input logic [23:0] t);
    int h10, h1, m10, m1, s10, s1;
    h10 = int'(t[23:20]); h1 = int'(t[19:16]); m10 = int'(t[15:12]);
    m1 = int'(t[11:8]); s10 = int'(t[7:4]); s1 = int'(t[3:0]);
    if (h1 > 9 || m1 > 9 || s1 > 9) return 1'b0;
    if (m10 > 5 || s10 > 5) return 1'b0;
    if (h10 * 10 + h1 > 23) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int to_sec(input logic [23:0] t);
    return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
           (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
           int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    logic [23:0] r;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    r[23:20] = 4'(h / 10); r[19:16] = 4'(h % 10);
    r[15:12] = 4'(m / 10); r[11:8]  = 4'(m % 10);
    r[7:4]   = 4'(x / 10); r[3:0]   = 4'(x % 10);
    return r;
  endfunction

  // Expected word: {negative, error, result digits}.
  function automatic logic [25:0] model(input logic [23:0] a, input logic [23:0] b);
    int d;
    if (!valid_t(a) || !valid_t(b)) return {2'b01, 24'd0};
    d = to_sec(a) - to_sec(b);
    if (d >= 0) return {2'b00, to_bcd(d)};
`ifdef WRAP_24H_EN
    return {2'b10, to_bcd(d + 86400)};
`else
    return {2'b10, 24'd0};
`endif
  endfunction

  function automatic logic [23:0] rand_time();
    return to_bcd(int'($urandom_range(0, 86399)));
  endfunction

  task automatic set_ops(input logic [23:0] a, input logic [23:0] b);
    {aHour10, aHour1, aMinute10, aMinute1, aSecond10, aSecond1} = a;
    {bHour10, bHour1, bMinute10, bMinute1, bSecond10, bSecond1} = b;
  endtask

  // Result comparison whenever complete is seen.
  always @(negedge clock) begin
    if (complete === 1'b1) begin
      logic [25:0] got, exp;
      got = {negative, error, Hour10, Hour1, Minute10, Minute1, Second10, Second1};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_complete: got %h, none expected", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL result: got neg/err/digits %h, expected %h", got, exp);
        end
      end
    end
  end

  // One operation with full latency checking; inj issues a stray start at E4.
  task automatic do_op(input logic [23:0] a, input logic [23:0] b, input bit inj);
    set_ops(a, b);
    start = 1'b1;
    @(posedge clock);
    exp_q.push_back(model(a, b));
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start = 1'b0;
        set_ops(rand_time(), rand_time());
      end
      if (inj && k == 4) begin
        set_ops(24'h010000, 24'h000000);
        start = 1'b1;
      end
      if (inj && k == 5) start = 1'b0;
      checks++;
      if (busy !== 1'b1 || complete !== 1'b0) begin
        errors++;
        $display("FAIL latency_busy: edge E%0d busy=%b complete=%b, required busy=1 complete=0",
                 k - 1, busy, complete);
      end
    end
    @(negedge clock);
    checks++;
    if (complete !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL latency_complete: after E7 complete=%b busy=%b, required 1/0", complete, busy);
    end
    @(negedge clock);
    checks++;
    if (complete !== 1'b0) begin
      errors++;
      $display("FAIL complete_pulse: after E8 complete=%b, required 0", complete);
    end
  endtask

  task automatic test_reset();
    set_ops(24'h0, 24'h0);
    start = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({Hour10, Hour1, Minute10, Minute1, Second10, Second1, complete, busy, negative, error,
         dbg_state} !== 30'd0) begin
      errors++;
      $display("FAIL reset_values: busy=%b complete=%b state=%0d, required all zero",
               busy, complete, dbg_state);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_op(24'h123045, 24'h081520, 1'b0);
    do_op(24'h100000, 24'h095959, 1'b0);
    do_op(24'h080000, 24'h223000, 1'b0);
  endtask

  task automatic test_error();
    do_op(24'h127100, 24'h010101, 1'b0);
    do_op(24'h050000, 24'h240000, 1'b0);
    do_op(24'h0A0000, 24'h000000, 1'b0);
  endtask

  task automatic test_reset_mid();
    // Operate first so the outputs hold a nonzero result.
    do_op(24'h123045, 24'h081520, 1'b0);
    set_ops(24'h200000, 24'h010000);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({Hour10, Hour1, Minute10, Minute1, Second10, Second1, complete, busy, negative,
         error} !== 28'd0) begin
      errors++;
      $display("FAIL reset_mid_op: digits=%h busy=%b neg=%b err=%b, required all zero",
               {Hour10, Hour1, Minute10, Minute1, Second10, Second1}, busy, negative, error);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: busy=%b after reset, required 0", busy);
      end
    end
  endtask

  task automatic test_ignored_start();
    do_op(24'h153000, 24'h150000, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL ignored_start: busy=%b, required 0", busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_ops(24'h235959, 24'h235959);
    start = 1'b1;
    @(posedge clock);
    exp_q.push_back(model(24'h235959, 24'h235959));
    exp_q.push_back(model(24'h235959, 24'h235959));
    for (int n = 1; n <= 20; n++) begin
      int e;
      logic exp_c, exp_b;
      @(negedge clock);
      e = n - 1;
      if (n == 9) start = 1'b0;
      exp_c = (e == 7) || (e == 15);
      exp_b = (e <= 6) || (e >= 8 && e <= 14);
      checks++;
      if (complete !== exp_c || busy !== exp_b) begin
        errors++;
        $display("FAIL back_to_back: E%0d complete=%b busy=%b, required %b/%b",
                 e, complete, busy, exp_c, exp_b);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [23:0] a, b;
      a = rand_time();
      b = rand_time();
      if ($urandom_range(0, 7) == 0) a[15:12] = 4'($urandom_range(6, 15));
      do_op(a, b, 1'b0);
    end
  endtask

  initial begin
    set_ops(24'h0, 24'h0);
    test_reset();
    test_basic();
    test_error();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    test_random();
    repeat (4) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_complete: %0d results never produced", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
